uart_cmd_sequencer: RTL and testbench

Command sequencer behind the UART packet receiver. On each completed packet it reads the payload from the receiver's packet buffer, executes the command against an 8-bit register bank and emits a checksummed response packet as a byte stream to the UART transmitter. One packet is processed at a time; packets arriving while busy are dropped and flagged.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_resp_tx.sv | 58 +++++
 rtl/uart_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet path: command/response codes,
// sequencer state encoding, address-width helper and checksum arithmetic.
package uart_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] CMD_PING    = 8'h03;

  localparam logic [7:0] RSP_WRITE   = 8'h81;
  localparam logic [7:0] RSP_READ    = 8'h82;
  localparam logic [7:0] RSP_PING    = 8'h83;
  localparam logic [7:0] RSP_BAD_LEN = 8'hFE;
  localparam logic [7:0] RSP_BAD_CMD = 8'hFF;

  localparam int MAX_READ_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC_WR,
    S_TX_CMD,
    S_TX_LEN,
    S_TX_DATA,
    S_TX_SUM
  } seq_state_t;

  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value - 1;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic [7:0] csum_final(input logic [7:0] acc);
    return ~acc;
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Response byte-stream stage: holds the presented byte under valid/ready,
// accumulates the running checksum and produces the final sum byte with tx_last.
module uart_resp_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       load_first,
  input  logic       load_sum,
  input  logic       load_live,
  input  logic [7:0] load_byte,
  input  logic [7:0] live_byte,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic       fire
);

  logic [7:0] data_q;
  logic [7:0] acc;
  logic       live;

  // Live bytes track the register bank directly so reg_addr and tx_data stay aligned.
  assign tx_data = live ? live_byte : data_q;
  assign fire    = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      data_q   <= '0;
      live     <= 1'b0;
      acc      <= '0;
    end else begin
      if (fire) begin
        acc <= csum_step(acc, tx_data);
      end
      if (load) begin
        tx_valid <= 1'b1;
        tx_last  <= load_sum;
        live     <= load_live;
        // The sum is only loaded on the handshake of the preceding byte, so fold it in here.
        data_q   <= load_sum ? csum_final(csum_step(acc, tx_data)) : load_byte;
        if (load_first) begin
          acc <= '0;
        end
      end else if (fire) begin
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
        live     <= 1'b0;
        data_q   <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Executes one received packet at a time against the register bank and
// streams back a checksummed response; packets arriving while busy are dropped.
module uart_cmd_sequencer
  import uart_pkg::*;
#(
  parameter int NUMBER   = 256,
  parameter int MAX_READ = MAX_READ_DEFAULT,
  localparam int AW      = clogb2(NUMBER)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pck_done,
  input  logic [7:0]    cmd_rx,
  input  logic [AW-1:0] len_rx,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    reg_addr,
  output logic          reg_wr_en,
  output logic [7:0]    reg_wr_data,
  input  logic [7:0]    reg_rd_data,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_last,
  input  logic          tx_ready,
  output logic          busy,
  output logic          overrun
);

  seq_state_t    state;
  logic [7:0]    cmd_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] wr_left;
  logic [7:0]    start_q;
  logic [7:0]    data_left;
  logic [7:0]    resp_cmd;
  logic [7:0]    resp_len;
  logic          read_resp;
  logic          fetch_ph;

  logic          base_ok;
  logic [7:0]    direct_cmd;
  logic [7:0]    direct_len;
  logic          count_ok;
  logic          fire;
  logic          load;
  logic          load_first;
  logic          load_sum;
  logic          load_live;
  logic [7:0]    load_byte;

  assign busy     = (state != S_IDLE);
  assign count_ok = (rd_data != 8'h00) && (rd_data <= 8'(MAX_READ));

  always_comb begin
    base_ok = ((cmd_rx == CMD_WRITE) && (len_rx >= AW'(2))) ||
              ((cmd_rx == CMD_READ)  && (len_rx == AW'(2)));
    if ((cmd_rx == CMD_PING) && (len_rx == '0)) begin
      direct_cmd = RSP_PING;
      direct_len = 8'h00;
    end else if ((cmd_rx == CMD_WRITE) || (cmd_rx == CMD_READ) || (cmd_rx == CMD_PING)) begin
      direct_cmd = RSP_BAD_LEN;
      direct_len = 8'h01;
    end else begin
      direct_cmd = RSP_BAD_CMD;
      direct_len = 8'h01;
    end
  end

  always_comb begin
    load       = 1'b0;
    load_first = 1'b0;
    load_sum   = 1'b0;
    load_live  = 1'b0;
    load_byte  = '0;
    case (state)
      S_IDLE: begin
        if (pck_done && !base_ok) begin
          load       = 1'b1;
          load_first = 1'b1;
          load_byte  = direct_cmd;
        end
      end
      S_FETCH: begin
        if (fetch_ph && (cmd_q == CMD_READ)) begin
          load       = 1'b1;
          load_first = 1'b1;
          load_byte  = count_ok ? RSP_READ : RSP_BAD_LEN;
        end
      end
      S_EXEC_WR: begin
        if (wr_left == '0) begin
          load       = 1'b1;
          load_first = 1'b1;
          load_byte  = RSP_WRITE;
        end
      end
      S_TX_CMD: begin
        if (fire) begin
          load      = 1'b1;
          load_byte = resp_len;
        end
      end
      S_TX_LEN: begin
        if (fire) begin
          load      = 1'b1;
          load_sum  = (resp_len == 8'h00);
          load_live = (resp_len != 8'h00) && read_resp;
          load_byte = cmd_q;
        end
      end
      S_TX_DATA: begin
        if (fire) begin
          load      = 1'b1;
          load_sum  = (data_left == 8'h00);
          load_live = (data_left != 8'h00);
        end
      end
      default: ;
    endcase
  end

  uart_resp_tx u_resp_tx (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_first (load_first),
    .load_sum   (load_sum),
    .load_live  (load_live),
    .load_byte  (load_byte),
    .live_byte  (reg_rd_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .fire       (fire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rd_addr     <= '0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      overrun     <= 1'b0;
      cmd_q       <= '0;
      len_q       <= '0;
      wr_left     <= '0;
      start_q     <= '0;
      data_left   <= '0;
      resp_cmd    <= '0;
      resp_len    <= '0;
      read_resp   <= 1'b0;
      fetch_ph    <= 1'b0;
    end else begin
      if (pck_done && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pck_done) begin
            cmd_q     <= cmd_rx;
            len_q     <= len_rx;
            fetch_ph  <= 1'b0;
            read_resp <= 1'b0;
            // Address 0 is already on the buffer while idle, so data0 arrives next cycle.
            if (base_ok) begin
              rd_addr <= AW'(1);
              state   <= S_FETCH;
            end else begin
              resp_cmd <= direct_cmd;
              resp_len <= direct_len;
              state    <= S_TX_CMD;
            end
          end
        end
        S_FETCH: begin
          if (!fetch_ph) begin
            start_q  <= rd_data;
            fetch_ph <= 1'b1;
            rd_addr  <= rd_addr + AW'(1);
          end else if (cmd_q == CMD_READ) begin
            rd_addr   <= '0;
            read_resp <= count_ok;
            resp_cmd  <= count_ok ? RSP_READ : RSP_BAD_LEN;
            resp_len  <= count_ok ? rd_data : 8'h01;
            state     <= S_TX_CMD;
          end else begin
            reg_wr_en   <= 1'b1;
            reg_wr_data <= rd_data;
            reg_addr    <= start_q;
            wr_left     <= len_q - AW'(2);
            rd_addr     <= rd_addr + AW'(1);
            resp_cmd    <= RSP_WRITE;
            resp_len    <= 8'h00;
            state       <= S_EXEC_WR;
          end
        end
        S_EXEC_WR: begin
          if (wr_left != '0) begin
            reg_wr_data <= rd_data;
            reg_addr    <= reg_addr + 8'h01;
            wr_left     <= wr_left - AW'(1);
            rd_addr     <= rd_addr + AW'(1);
          end else begin
            reg_wr_en <= 1'b0;
            rd_addr   <= '0;
            state     <= S_TX_CMD;
          end
        end
        S_TX_CMD: begin
          if (fire) begin
            state <= S_TX_LEN;
          end
        end
        S_TX_LEN: begin
          if (fire) begin
            if (resp_len == 8'h00) begin
              state <= S_TX_SUM;
            end else begin
              data_left <= resp_len - 8'h01;
              if (read_resp) begin
                reg_addr <= start_q;
              end
              state <= S_TX_DATA;
            end
          end
        end
        S_TX_DATA: begin
          if (fire) begin
            if (data_left == 8'h00) begin
              state <= S_TX_SUM;
            end else begin
              data_left <= data_left - 8'h01;
              reg_addr  <= reg_addr + 8'h01;
            end
          end
        end
        S_TX_SUM: begin
          if (fire) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: stimulus pushes expected response
// bytes and register writes; negedge monitors pop and compare.
module tb_uart_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pck_done = 1'b0;
  logic [7:0] cmd_rx = 8'h00;
  logic [7:0] len_rx = 8'h00;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       overrun;

  logic [7:0] buf_mem [256];
  logic [7:0] regs [256];
  logic [7:0] blk [16];

  logic [8:0]  exp_tx [$];
  logic [15:0] exp_wr [$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int t0 = 0;
  int first_tx = -1;
  int first_wr = -1;
  int last_wr = -1;
  int popped = 0;
  logic hold = 1'b0;
  logic [8:0] held = '0;
  logic rand_ready = 1'b0;

  uart_cmd_sequencer #(.NUMBER(256), .MAX_READ(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .pck_done    (pck_done),
    .cmd_rx      (cmd_rx),
    .len_rx      (len_rx),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= buf_mem[rd_addr];
    if (reg_wr_en) regs[reg_addr] <= reg_wr_data;
  end

  assign reg_rd_data = regs[reg_addr];

  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) check("tx_hold_stable", {tx_valid, tx_last, tx_data}, {1'b1, held});
      if (tx_valid && first_tx < 0) first_tx = cyc;
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx_unexpected: got byte 0x%02h last=%0b, expected no byte", tx_data, tx_last);
        end else begin
          check("tx_byte", {tx_last, tx_data}, exp_tx.pop_front());
        end
        popped++;
      end
      hold = tx_valid && !tx_ready;
      held = {tx_last, tx_data};
      if (reg_wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_wr.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL wr_unexpected: got write 0x%02h->0x%02h, expected none", reg_wr_data, reg_addr);
        end else begin
          check("reg_write", {reg_addr, reg_wr_data}, exp_wr.pop_front());
        end
      end
    end
  end

  task automatic exp_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    logic [7:0] b [5];
    b = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < n; i++) exp_tx.push_back({(i == n - 1), b[i]});
  endtask

  task automatic push_read16();
    logic [7:0] acc;
    acc = 8'h82 + 8'h10;
    exp_tx.push_back({1'b0, 8'h82});
    exp_tx.push_back({1'b0, 8'h10});
    for (int i = 0; i < 16; i++) begin
      exp_tx.push_back({1'b0, blk[i]});
      acc = acc + blk[i];
    end
    exp_tx.push_back({1'b1, ~acc});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    compared++;
    mismatched++;
    $display("FAIL idle_timeout: busy=1 after 400 cycles, expected 0");
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] l, input int tx_lat,
                      input int wr_n, input int inject);
    @(posedge clk); #1;
    cmd_rx = c; len_rx = l; pck_done = 1'b1;
    t0 = cyc; first_tx = -1; first_wr = -1; last_wr = -1;
    @(posedge clk); #1;
    pck_done = 1'b0;
    check("busy_rise", busy, 1);
    if (inject > 0) begin
      repeat (inject) @(posedge clk);
      #1;
      cmd_rx = 8'h03; len_rx = 8'h00; pck_done = 1'b1;
      @(posedge clk); #1;
      pck_done = 1'b0;
      check("overrun_set", overrun, 1);
    end
    wait_idle();
    check("tx_latency", 32'(first_tx - t0), 32'(tx_lat));
    if (wr_n > 0) begin
      check("wr_latency", 32'(first_wr - t0), 32'd3);
      check("wr_consecutive", 32'(last_wr - first_wr), 32'(wr_n - 1));
    end
    check("tx_drained", exp_tx.size(), 0);
    check("wr_drained", exp_wr.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_rd_addr", rd_addr, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wr_en", reg_wr_en, 0);
    check("rst_reg_wr_data", reg_wr_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      buf_mem[i] = 8'h00;
      regs[i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) blk[i] = 8'(i * 37 + 5);

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk) reset = 1'b1;

    // PING
    exp_bytes(3, 8'h83, 8'h00, 8'h7C, 8'h00, 8'h00);
    send(8'h03, 8'h00, 1, 0, 0);

    // WRITE 0xAA->0x10, 0x55->0x11
    buf_mem[0] = 8'h10; buf_mem[1] = 8'hAA; buf_mem[2] = 8'h55;
    exp_wr.push_back({8'h10, 8'hAA});
    exp_wr.push_back({8'h11, 8'h55});
    exp_bytes(3, 8'h81, 8'h00, 8'h7E, 8'h00, 8'h00);
    send(8'h01, 8'h03, 5, 2, 0);

    // WRITE wrapping 0xFF -> 0x00, seeds the READ below
    buf_mem[0] = 8'hFF; buf_mem[1] = 8'h12; buf_mem[2] = 8'h34;
    exp_wr.push_back({8'hFF, 8'h12});
    exp_wr.push_back({8'h00, 8'h34});
    exp_bytes(3, 8'h81, 8'h00, 8'h7E, 8'h00, 8'h00);
    send(8'h01, 8'h03, 5, 2, 0);

    // READ at 0xFF count 2
    buf_mem[0] = 8'hFF; buf_mem[1] = 8'h02;
    exp_bytes(5, 8'h82, 8'h02, 8'h12, 8'h34, 8'h35);
    send(8'h02, 8'h02, 3, 0, 0);

    // READ count 0 and count 17
    buf_mem[0] = 8'h20; buf_mem[1] = 8'h00;
    exp_bytes(4, 8'hFE, 8'h01, 8'h02, 8'hFE, 8'h00);
    send(8'h02, 8'h02, 3, 0, 0);
    buf_mem[1] = 8'h11;
    exp_bytes(4, 8'hFE, 8'h01, 8'h02, 8'hFE, 8'h00);
    send(8'h02, 8'h02, 3, 0, 0);

    // Unknown command, bad base lengths
    exp_bytes(4, 8'hFF, 8'h01, 8'h40, 8'hBF, 8'h00);
    send(8'h40, 8'h00, 1, 0, 0);
    exp_bytes(4, 8'hFE, 8'h01, 8'h03, 8'hFD, 8'h00);
    send(8'h03, 8'h01, 1, 0, 0);
    exp_bytes(4, 8'hFE, 8'h01, 8'h01, 8'hFF, 8'h00);
    send(8'h01, 8'h01, 1, 0, 0);
    exp_bytes(4, 8'hFE, 8'h01, 8'h02, 8'hFE, 8'h00);
    send(8'h02, 8'h03, 1, 0, 0);

    // WRITE 16 values at 0x30
    buf_mem[0] = 8'h30;
    for (int i = 0; i < 16; i++) begin
      buf_mem[i + 1] = blk[i];
      exp_wr.push_back({8'(8'h30 + i), blk[i]});
    end
    exp_bytes(3, 8'h81, 8'h00, 8'h7E, 8'h00, 8'h00);
    send(8'h01, 8'h11, 19, 16, 0);

    // READ 16 with random tx_ready, plus a dropped packet while busy
    buf_mem[0] = 8'h30; buf_mem[1] = 8'h10;
    push_read16();
    rand_ready = 1'b1;
    send(8'h02, 8'h02, 3, 0, 4);
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    check("overrun_sticky", overrun, 1);

    // Reset during TX_DATA
    push_read16();
    @(posedge clk); #1;
    cmd_rx = 8'h02; len_rx = 8'h02; pck_done = 1'b1;
    @(posedge clk); #1;
    pck_done = 1'b0;
    begin
      int p0;
      bit reached;
      p0 = popped - 0;
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
        @(negedge clk);
        if (popped >= p0 + 3) reached = 1'b1;
      end
      if (!reached) begin
        compared++;
        mismatched++;
        $display("FAIL reach_tx_data: 3 bytes not accepted within 100 cycles, expected reached");
      end
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    #1;
    check("mid_data_valid", tx_valid, 1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    exp_tx.delete();
    exp_wr.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tx_ready = 1'b1;

    exp_bytes(3, 8'h83, 8'h00, 8'h7C, 8'h00, 8'h00);
    send(8'h03, 8'h00, 1, 0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
